// File: rtl/uvc_iso_scheduler.sv
// uvc_iso_scheduler: buffers pixel bytes and emits one UVC iso packet per SOF.
// Optional statistics counters are enabled with UVC_SCHED_STAT_EN.
module uvc_iso_scheduler #(
  parameter logic [23:0] FRAME_BYTES = 24'd153600,
  parameter logic [9:0]  PAYLOAD_MAX = 10'd800,
  parameter int          FIFO_AW     = 11
) (
  input  logic             clk,
  input  logic             usb_rstn,
  input  logic             sof,
  input  logic [7:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [7:0]       ep_data,
  output logic             ep_valid,
  input  logic             ep_ready,
  output logic             fid,
  output logic             frame_done,
  output logic [FIFO_AW:0] fifo_level
`ifdef UVC_SCHED_STAT_EN
  ,
  output logic [15:0]      stat_empty,
  output logic [15:0]      stat_late
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    PAY
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             rdy_q;
  logic [23:0]      remaining;
  logic [10:0]      cnt_q;
  logic             eof_q;
  logic             fid_q;
  logic             fd_q;

  logic             wr_en;
  logic             pop;
  logic             start;
  logic             last_pay;
  logic [23:0]      lvl_w;
  logic [23:0]      m1;
  logic [23:0]      m2;
  logic [10:0]      len_d;
  logic             eof_d;

  assign fifo_level = wr_ptr - rd_ptr;
  assign src_ready  = rdy_q && (fifo_level != (FIFO_AW+1)'(DEPTH));
  assign wr_en      = src_valid && src_ready;
  assign start      = (state_q == IDLE) && sof;
  assign pop        = (state_q == PAY) && ep_ready;
  assign last_pay   = pop && (cnt_q == 11'd1);
  assign fid        = fid_q;
  assign frame_done = fd_q;

  // Packet length: the smaller of buffered bytes, max payload, frame remainder.
  always_comb begin
    lvl_w = 24'(fifo_level);
    m1    = (lvl_w < 24'(PAYLOAD_MAX)) ? lvl_w : 24'(PAYLOAD_MAX);
    m2    = (m1 < remaining) ? m1 : remaining;
    len_d = 11'(m2);
    eof_d = (m2 == remaining) && (m2 != 24'd0);
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= src_data;
  end

  // FIFO pointers; reset flushes the buffer.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic; sof outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sof) state_d = HDR0;
      HDR0: if (ep_ready) state_d = HDR1;
      HDR1: if (ep_ready) state_d = (cnt_q != 11'd0) ? PAY : IDLE;
      PAY:  if (last_pay) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: header bytes, then FIFO head (first-word-fall-through).
  always_comb begin
    ep_valid = 1'b0;
    ep_data  = 8'h00;
    unique case (state_q)
      IDLE: ;
      HDR0: begin
        ep_valid = 1'b1;
        ep_data  = 8'h02;
      end
      HDR1: begin
        ep_valid = 1'b1;
        ep_data  = {6'b100000, eof_q, fid_q};
      end
      PAY: begin
        ep_valid = 1'b1;
        ep_data  = mem[rd_ptr[FIFO_AW-1:0]];
      end
      default: ;
    endcase
  end

  // Packet length, frame position and frame-ID tracking.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      rdy_q     <= 1'b0;
      remaining <= FRAME_BYTES;
      cnt_q     <= '0;
      eof_q     <= 1'b0;
      fid_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      fd_q  <= 1'b0;
      if (start) begin
        cnt_q <= len_d;
        eof_q <= eof_d;
      end
      if (pop) begin
        cnt_q     <= cnt_q - 11'd1;
        remaining <= remaining - 24'd1;
      end
      if (last_pay && eof_q) begin
        fid_q     <= ~fid_q;
        remaining <= FRAME_BYTES;
        fd_q      <= 1'b1;
      end
    end
  end

`ifdef UVC_SCHED_STAT_EN
  // Saturating counters for header-only packets and ignored sofs.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      stat_empty <= '0;
      stat_late  <= '0;
    end else begin
      if (start && (len_d == 11'd0) && (stat_empty != 16'hFFFF))
        stat_empty <= stat_empty + 16'd1;
      if (sof && (state_q != IDLE) && (stat_late != 16'hFFFF))
        stat_late <= stat_late + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uvc_iso_scheduler.sv
// tb_uvc_iso_scheduler: directed vectors for the UVC iso scheduler.
// Stat checks run when UVC_SCHED_STAT_EN is defined for the build.
module tb_uvc_iso_scheduler;

  logic       clk;
  logic       usb_rstn;
  logic       sof;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] ep_data;
  logic       ep_valid;
  logic       ep_ready;
  logic       fid;
  logic       frame_done;
  logic [3:0] fifo_level;
`ifdef UVC_SCHED_STAT_EN
  logic [15:0] stat_empty;
  logic [15:0] stat_late;
`endif

  uvc_iso_scheduler #(
    .FRAME_BYTES(24'd10),
    .PAYLOAD_MAX(10'd4),
    .FIFO_AW(3)
  ) dut (
    .clk(clk),
    .usb_rstn(usb_rstn),
    .sof(sof),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .ep_data(ep_data),
    .ep_valid(ep_valid),
    .ep_ready(ep_ready),
    .fid(fid),
    .frame_done(frame_done),
    .fifo_level(fifo_level)
`ifdef UVC_SCHED_STAT_EN
    ,
    .stat_empty(stat_empty),
    .stat_late(stat_late)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         wr_start;
    int         wr_cnt;
    int         len;
    logic [7:0] hdr1;
    logic [7:0] first;
    int         level;
    logic       fid;
    logic       fd;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] got [$];
  logic       fd_seen;
  int         n_chk;
  int         n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic write_bytes(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      src_data  = 8'(start + i);
      src_valid = 1'b1;
      @(negedge clk);
    end
    src_valid = 1'b0;
  endtask

  // Gather packet bytes until ep_valid falls; optional 5-cycle stall.
  task automatic collect(input int stall_at);
    int   k;
    bit   done;
    bit   stalled;
    logic [7:0] held;
    k = 0;
    done = 0;
    stalled = 0;
    got.delete();
    fd_seen = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (ep_valid) begin
        if (k == stall_at && !stalled) begin
          stalled  = 1;
          held     = ep_data;
          ep_ready = 1'b0;
          for (int j = 0; j < 5; j++) begin
            if (j == 1) sof = 1'b1;
            if (j == 2) sof = 1'b0;
            @(negedge clk);
            chk("stall_valid", 32'(ep_valid), 32'd1);
            chk("stall_data", 32'(ep_data), 32'(held));
          end
          ep_ready = 1'b1;
        end
        got.push_back(ep_data);
        k++;
        @(negedge clk);
      end else begin
        fd_seen = frame_done;
        done = 1;
      end
    end
    if (!done) chk("pkt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_pkt(input string nm, input int len,
                           input logic [7:0] hdr1,
                           input logic [7:0] first);
    chk({nm, "_size"}, 32'(got.size()), 32'(len + 2));
    if (got.size() >= 2) begin
      chk({nm, "_hdr0"}, 32'(got[0]), 32'h02);
      chk({nm, "_hdr1"}, 32'(got[1]), 32'(hdr1));
    end
    for (int p = 0; p < len; p++)
      if (p + 2 < got.size())
        chk({nm, "_pay"}, 32'(got[p + 2]), 32'(8'(first + p)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{0, 8, 4, 8'h80, 8'h00, 4, 1'b0, 1'b0};
    vecs[1] = '{0, 0, 4, 8'h80, 8'h04, 0, 1'b0, 1'b0};
    vecs[2] = '{8, 2, 2, 8'h82, 8'h08, 0, 1'b1, 1'b1};
    vecs[3] = '{0, 0, 0, 8'h81, 8'h00, 0, 1'b1, 1'b0};

    usb_rstn  = 1'b0;
    sof       = 1'b0;
    src_data  = 8'h00;
    src_valid = 1'b0;
    ep_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ep_valid", 32'(ep_valid), 32'd0);
    chk("rst_ep_data", 32'(ep_data), 32'h00);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_fid", 32'(fid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
`ifdef UVC_SCHED_STAT_EN
    chk("rst_stat_empty", 32'(stat_empty), 32'd0);
    chk("rst_stat_late", 32'(stat_late), 32'd0);
`endif
    usb_rstn = 1'b1;
    @(negedge clk);
    chk("src_ready_after_rst", 32'(src_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      write_bytes(vecs[i].wr_start, vecs[i].wr_cnt);
      pulse_sof();
      collect(-1);
      check_pkt("vec", vecs[i].len, vecs[i].hdr1, vecs[i].first);
      chk("vec_frame_done", 32'(fd_seen), 32'(vecs[i].fd));
      chk("vec_level", 32'(fifo_level), 32'(vecs[i].level));
      @(negedge clk);
      chk("vec_fd_one_cycle", 32'(frame_done), 32'd0);
      chk("vec_ep_valid_idle", 32'(ep_valid), 32'd0);
      chk("vec_fid", 32'(fid), 32'(vecs[i].fid));
    end
`ifdef UVC_SCHED_STAT_EN
    chk("stat_empty", 32'(stat_empty), 32'd1);
`endif

    // FIFO fill: 9 offered bytes, only 8 accepted.
    for (int i = 0; i < 9; i++) begin
      src_data  = 8'(8'h10 + i);
      src_valid = 1'b1;
      chk("fill_ready", 32'(src_ready), (i < 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("full_ready", 32'(src_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd8);
    src_valid = 1'b0;

    // Stall mid-payload with an sof arriving during the stall.
    pulse_sof();
    collect(3);
    check_pkt("stall", 4, 8'h81, 8'h10);
    chk("stall_level", 32'(fifo_level), 32'd4);
`ifdef UVC_SCHED_STAT_EN
    chk("stat_late", 32'(stat_late), 32'd1);
`endif
    @(negedge clk);
    chk("stall_no_extra_pkt", 32'(ep_valid), 32'd0);

    // Reset during the payload phase.
    pulse_sof();
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(ep_valid), 32'd1);
    chk("pre_rst_data", 32'(ep_data), 32'h14);
    usb_rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ep_valid), 32'd0);
    chk("mid_rst_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    usb_rstn = 1'b1;
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_fid", 32'(fid), 32'd0);
`ifdef UVC_SCHED_STAT_EN
    chk("post_rst_stat_late", 32'(stat_late), 32'd0);
`endif
    @(negedge clk);
    chk("post_rst_src_ready", 32'(src_ready), 32'd1);
    pulse_sof();
    collect(-1);
    check_pkt("post_rst", 0, 8'h80, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uvc_iso_scheduler.md
# uvc_iso_scheduler

Isochronous UVC packet scheduler between a pixel producer and the EP81 IN endpoint of the USB full-speed core. Buffers pixel bytes in an internal FIFO. On each USB start-of-frame, it sizes one UVC payload packet from the bytes already buffered, then emits the 2-byte UVC header followed by the payload. It tracks video-frame boundaries, so an underrunning source shortens packets instead of breaking them mid-transfer.

## Interface
- FRAME_BYTES, 24'd153600: bytes per video frame; range 1..2^24-1.
- PAYLOAD_MAX, 10'd800: maximum payload bytes per packet, excluding the header; range 1..1021.
- FIFO_AW, 11: FIFO address width; depth is 2^FIFO_AW bytes.
- clk  in  1  USB core clock.
- usb_rstn  in  1  reset, asynchronous, active-low.
- sof  in  1  one-cycle USB start-of-frame pulse from the core.
- src_data  in  8  pixel byte.
- src_valid  in  1  src_data is valid.
- src_ready  out  1  FIFO not full; a byte is written when src_valid & src_ready.
- ep_data  out  8  byte to EP81; valid while ep_valid=1.
- ep_valid  out  1  packet byte available; deasserts to end the packet.
- ep_ready  in  1  EP81 accepts ep_data this cycle.
- fid  out  1  current UVC frame-ID bit.
- frame_done  out  1  one-cycle pulse after the EOF packet completes.
- fifo_level  out  FIFO_AW+1  bytes currently buffered.
- stat_empty  out  16  count of header-only packets. Present only with UVC_SCHED_STAT_EN.
- stat_late  out  16  count of sof pulses ignored while busy. Present only with UVC_SCHED_STAT_EN.

## Operation
- FSM states:
  - IDLE -(sof)-> HDR0 -(accept)-> HDR1.
  - HDR1 -(accept, len>0)-> PAY; HDR1 -(accept, len=0)-> IDLE.
  - PAY -(accept of last byte)-> IDLE.
- On sof in IDLE, latch len = min(fifo_level, PAYLOAD_MAX, remaining) as an 11-bit unsigned value.
- Also latch eof = (len == remaining) && (len != 0).
- Header bytes:
  - HDR0: ep_data = 8'h02.
  - HDR1: ep_data = {6'b100000, eof, fid}.
- PAY: ep_data = FIFO head, first-word-fall-through. Each accept pops one byte and decrements remaining by 1 (24-bit).
- Bytes written during a packet do not extend len; len is fixed at the sof that starts the packet.
- End of an EOF packet, on the cycle after the last accept:
  - fid toggles.
  - remaining reloads to FRAME_BYTES.
  - frame_done pulses for one cycle.
- len=0 (FIFO empty at sof) emits a header-only packet with eof=0.
- sof in any state other than IDLE is ignored; the packet in flight completes unchanged.
- FIFO write and read in the same cycle leave fifo_level unchanged. When full, src_ready=0 and input is not consumed.
- ep_valid stays 1 and ep_data stays stable until accepted, including across ep_ready=0 stalls.

## Timing
- Reset values:
  - ep_valid=0, ep_data=8'h00, src_ready=0 while usb_rstn=0, frame_done=0.
  - fid=0, fifo_level=0, remaining=FRAME_BYTES, state IDLE.
  - stat counters=0.
- After usb_rstn releases, src_ready=1 from the first clk edge.
- Latency: sof sampled at edge t gives ep_valid=1 with 8'h02 after edge t, i.e. in cycle t+1.
- Throughput: one byte per cycle while ep_ready=1. The packet takes len+2 accepts.
- After the final accept, ep_valid=0 in the next cycle.
- A sof arriving in the same cycle as the final accept is ignored.
- Reset mid-packet:
  - ep_valid drops immediately (asynchronous).
  - FIFO is flushed; fid returns to 0.
  - The partial packet is abandoned.
- Statistics counters saturate at 16'hFFFF.

## Configuration
- UVC_SCHED_STAT_EN defined:
  - stat_empty increments at sof when len=0.
  - stat_late increments on every ignored sof.
- UVC_SCHED_STAT_EN undefined: stat_empty, stat_late ports and their counters are removed; all other behaviour is identical.

## Test plan
Test parameters: FRAME_BYTES=10, PAYLOAD_MAX=4, FIFO_AW=3, UVC_SCHED_STAT_EN defined.
- Write bytes 00..07, then pulse sof -> ep bytes 02,80,00,01,02,03; fifo_level=4 afterwards.
- Pulse sof again -> 02,80,04,05,06,07. Write 08,09, pulse sof -> 02,82,08,09; frame_done pulses one cycle later; fid=1.
- FIFO empty, pulse sof -> 02,81 only; ep_valid=0 next cycle; stat_empty=1.
- Write 9 bytes with src_valid held -> src_ready=0 after the 8th write; the 9th byte is not consumed; fifo_level=8.
- Hold ep_ready=0 for 5 cycles mid-payload and pulse sof during the stall -> ep_data held stable; packet completes intact; stat_late=1.
- Assert usb_rstn=0 in PAY state -> ep_valid=0 at once; after release fifo_level=0, fid=0; the next sof yields 02,80.
